// File: rtl/ctrl_frame_port_arbiter_pkg.sv
// Shared definitions for the frame-granular port arbiter: FSM encoding,
// port-id width, watchdog defaults and the round-robin pointer helper.
package ctrl_frame_port_arbiter_pkg;

  localparam int PORT_ID_W          = 3;
  localparam int WDT_CNT_W          = 16;
  localparam int WDT_CYCLES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2
  } arb_state_e;

  // Port index after 'id', wrapping at 'num_ports'.
  function automatic logic [PORT_ID_W-1:0] wrap_inc(input logic [PORT_ID_W-1:0] id,
                                                   input int num_ports);
    if (int'(id) + 1 >= num_ports) return '0;
    return id + PORT_ID_W'(1);
  endfunction

endpackage

// File: rtl/ctrl_frame_port_arbiter_rr_picker.sv
// Combinational round-robin winner select: first requesting port at or after
// rr_ptr, wrapping back to port 0.
module rr_picker
  import ctrl_frame_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_ID_W-1:0] rr_ptr,
  output logic [PORT_ID_W-1:0] winner,
  output logic                 any_req
);

  logic [NUM_PORTS-1:0] upper_req;
  logic [PORT_ID_W-1:0] upper_win;
  logic [PORT_ID_W-1:0] lower_win;

  // The rotation is realised as two priority encodes: ports at or above the
  // pointer win first, otherwise the search wraps to the lowest request.
  always_comb begin
    upper_req = '0;
    upper_win = '0;
    lower_win = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      upper_req[i] = req[i] && (PORT_ID_W'(i) >= rr_ptr);
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (upper_req[i]) upper_win = PORT_ID_W'(i);
      if (req[i])       lower_win = PORT_ID_W'(i);
    end
    any_req = |req;
    winner  = (|upper_req) ? upper_win : lower_win;
  end

endmodule

// File: rtl/ctrl_frame_port_arbiter.sv
// Frame-granular round-robin arbiter muxing NUM_PORTS header/body FIFOs onto one
// consumer. Optional watchdog enabled by defining CTRL_ARB_WATCHDOG_EN.
module ctrl_frame_port_arbiter
  import ctrl_frame_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int HEADER_DWIDTH = 128,
  parameter int WDT_CYCLES    = WDT_CYCLES_DEFAULT
) (
  input  logic                               clk,
  input  logic                               arst_n,
  input  logic [NUM_PORTS*HEADER_DWIDTH-1:0] s_h_fifo_dout,
  input  logic [NUM_PORTS-1:0]               s_h_fifo_empty,
  output logic [NUM_PORTS-1:0]               s_h_fifo_rden,
  input  logic [NUM_PORTS*8-1:0]             s_b_fifo_dout,
  input  logic [NUM_PORTS-1:0]               s_b_fifo_empty,
  input  logic [NUM_PORTS-1:0]               s_b_fifo_del,
  output logic [NUM_PORTS-1:0]               s_b_fifo_rden,
  output logic [HEADER_DWIDTH-1:0]           m_h_fifo_dout,
  output logic                               m_h_fifo_empty,
  input  logic                               m_h_fifo_rden,
  output logic [7:0]                         m_b_fifo_dout,
  output logic                               m_b_fifo_empty,
  output logic                               m_b_fifo_del,
  input  logic                               m_b_fifo_rden,
  output logic [2:0]                         m_port_id,
  output logic                               m_grant_valid,
  output logic                               wdt_err
);

  arb_state_e           state, state_next;
  logic [PORT_ID_W-1:0] grant_id, grant_id_next;
  logic [PORT_ID_W-1:0] rr_ptr, rr_ptr_next;
  logic                 grant_valid;
  logic [PORT_ID_W-1:0] winner;
  logic                 any_req;
  logic                 wdt_fire;

  rr_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_picker (
    .req    (~s_h_fifo_empty),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .any_req(any_req)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_next;
      grant_id    <= grant_id_next;
      rr_ptr      <= rr_ptr_next;
      grant_valid <= (state_next == S_HOLD);
    end
  end

  // A frame ends only on a header pop (or a watchdog timeout); the pointer
  // advances during the release cycle so the next pick starts after this port.
  always_comb begin
    state_next    = state;
    grant_id_next = grant_id;
    rr_ptr_next   = rr_ptr;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          grant_id_next = winner;
          state_next    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (m_h_fifo_rden || wdt_fire) state_next = S_RELEASE;
      end
      S_RELEASE: begin
        rr_ptr_next = wrap_inc(grant_id, NUM_PORTS);
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef CTRL_ARB_WATCHDOG_EN
  logic [WDT_CNT_W-1:0] wdt_cnt;
  logic                 wdt_err_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wdt_cnt   <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      if (state != S_HOLD)  wdt_cnt <= '0;
      else                  wdt_cnt <= wdt_cnt + WDT_CNT_W'(1);
      if (wdt_fire)         wdt_err_q <= 1'b1;
    end
  end

  // A header pop in the final cycle still ends the frame normally.
  assign wdt_fire = (state == S_HOLD) && !m_h_fifo_rden &&
                    (wdt_cnt == WDT_CNT_W'(WDT_CYCLES - 1));
  assign wdt_err  = wdt_err_q;
`else
  assign wdt_fire = 1'b0;
  assign wdt_err  = 1'b0;
`endif

  // Data path is purely combinational from the registered grant, so no
  // latency is added and nothing leaks through outside S_HOLD.
  always_comb begin
    m_h_fifo_dout  = '0;
    m_h_fifo_empty = 1'b1;
    m_b_fifo_dout  = '0;
    m_b_fifo_empty = 1'b1;
    m_b_fifo_del   = 1'b0;
    s_h_fifo_rden  = '0;
    s_b_fifo_rden  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_valid && (grant_id == PORT_ID_W'(i))) begin
        m_h_fifo_dout    = s_h_fifo_dout[i*HEADER_DWIDTH +: HEADER_DWIDTH];
        m_h_fifo_empty   = s_h_fifo_empty[i];
        m_b_fifo_dout    = s_b_fifo_dout[i*8 +: 8];
        m_b_fifo_empty   = s_b_fifo_empty[i];
        m_b_fifo_del     = s_b_fifo_del[i];
        s_h_fifo_rden[i] = m_h_fifo_rden;
        s_b_fifo_rden[i] = m_b_fifo_rden;
      end
    end
  end

  assign m_port_id     = grant_valid ? grant_id : '0;
  assign m_grant_valid = grant_valid;

endmodule
